// File: rtl/bsg_fifo_1r1w_sync_mem.sv
// bsg_fifo_1r1w_sync_mem
//   Ready/valid-in, valid/yumi-out FIFO wrapped around a 1r1w synchronous
//   RAM. The controller owns the RAM pointers and occupancy. A one-entry
//   output stage hides the RAM's one-cycle read latency. Total capacity is
//   els_p (RAM) + 1 (output stage).
//
//   Optional build macro: BSG_FIFO_SYNC_MEM_BYPASS_EN
//     When defined, a write into an otherwise empty FIFO goes straight to
//     the output stage. This gives a 1-cycle empty-to-valid latency instead
//     of 2 cycles.
//
//   Ports
//     clk_i    : clock, rising edge
//     reset_i  : synchronous, active-high reset
//     v_i      : input valid
//     data_i   : input data [width_p]
//     ready_o  : can accept; a write happens iff v_i & ready_o
//     v_o      : data_o holds the head element
//     data_o   : head element [width_p]
//     yumi_i   : consumer takes the head this cycle (only while v_o=1)

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

// Behavioural 1r1w synchronous RAM. r_data_o is registered and only
// updates on r_v_i, so it is not guaranteed to hold a value across reads.
module bsg_mem_1r1w_sync #(
  parameter int width_p       = 8,
  parameter int els_p         = 16,
  parameter int harden_p      = 1,
  parameter int addr_width_lp = `BSG_SAFE_CLOG2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);
  logic [width_p-1:0] r_mem [els_p];
  logic [width_p-1:0] r_data;

  // The hardened path is where a tech-mapped macro gets bound. Both
  // branches model the same behaviour, so simulation matches either way.
  if (harden_p != 0) begin : g_hard
    always_ff @(posedge clk_i) begin
      if (w_v_i) r_mem[w_addr_i] <= w_data_i;
      if (r_v_i) r_data <= r_mem[r_addr_i];
    end
  end else begin : g_soft
    always_ff @(posedge clk_i) begin
      if (w_v_i) r_mem[w_addr_i] <= w_data_i;
      if (r_v_i) r_data <= r_mem[r_addr_i];
    end
  end

  assign r_data_o = r_data;
endmodule

module bsg_fifo_1r1w_sync_mem #(
  parameter int width_p      = 8,
  parameter int els_p        = 16,
  parameter int harden_p     = 1,
  parameter int ptr_width_lp = `BSG_SAFE_CLOG2(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam logic [ptr_width_lp:0] FULL_CNT = (ptr_width_lp+1)'(els_p);

  logic [ptr_width_lp-1:0] r_wptr, r_rptr;
  logic [ptr_width_lp:0]   r_count;
  logic                    r_out_v, r_hold_v;
  logic [width_p-1:0]      r_hold_data;

  logic               w_write, w_slot_free, w_read_issue, w_bypass, w_mem_w;
  logic [width_p-1:0] w_mem_data;

  assign ready_o = (r_count != FULL_CNT);
  assign w_write = v_i & ready_o;

  // The output stage can take a new element if it is empty or being drained.
  assign w_slot_free = ~r_out_v | yumi_i;

  // r_count does not yet include this cycle's write. Because of that, a
  // read never targets the address being written in the same cycle.
  assign w_read_issue = (r_count != '0) & w_slot_free;

`ifdef BSG_FIFO_SYNC_MEM_BYPASS_EN
  // With the RAM empty, an incoming element can go straight to the output
  // stage. The read issue path is idle here because r_count is 0.
  assign w_bypass = w_write & (r_count == '0) & w_slot_free;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_mem_w = w_write & ~w_bypass;

  bsg_mem_1r1w_sync #(
    .width_p (width_p),
    .els_p   (els_p),
    .harden_p(harden_p)
  ) u_mem (
    .clk_i   (clk_i),
    .w_v_i   (w_mem_w),
    .w_addr_i(r_wptr),
    .w_data_i(data_i),
    .r_v_i   (w_read_issue),
    .r_addr_i(r_rptr),
    .r_data_o(w_mem_data)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_out_v  <= 1'b0;
      r_hold_v <= 1'b0;
    end else begin
      if (w_mem_w)      r_wptr <= r_wptr + 1'b1;
      if (w_read_issue) r_rptr <= r_rptr + 1'b1;
      r_count  <= r_count + (ptr_width_lp+1)'(w_mem_w)
                          - (ptr_width_lp+1)'(w_read_issue);
      r_out_v  <= w_read_issue | w_bypass | (r_out_v & ~yumi_i);
      // After a read issue, the head comes from the RAM output for one
      // cycle. From then on it comes from the hold register.
      r_hold_v <= ~w_read_issue;
    end
  end

  // Datapath only: no reset needed. It captures RAM data in the first
  // cycle after a read, because the RAM output may change later.
  always_ff @(posedge clk_i) begin
    if (w_bypass)       r_hold_data <= data_i;
    else if (~r_hold_v) r_hold_data <= w_mem_data;
  end

  assign v_o    = r_out_v;
  assign data_o = r_hold_v ? r_hold_data : w_mem_data;

  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
    yumi_i |-> r_out_v);
  a_no_same_addr: assert property (@(posedge clk_i) disable iff (reset_i)
    !(w_mem_w && w_read_issue && (r_wptr == r_rptr)));
endmodule

// File: tb/tb_bsg_fifo_1r1w_sync_mem.sv
module tb_bsg_fifo_1r1w_sync_mem;
  localparam int W = 8;
  localparam int E = 16;
`ifdef BSG_FIFO_SYNC_MEM_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         v_i = 1'b0, yumi_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         ready_o, v_o;
  logic [W-1:0] data_o;

  int n_checks = 0;
  int n_fail   = 0;

  bsg_fifo_1r1w_sync_mem #(.width_p(W), .els_p(E), .harden_p(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs, then move to 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic y);
    v_i = v; data_i = d; yumi_i = y;
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset;
    reset_i = 1'b1;
    cyc(1'b0, '0, 1'b0);
    reset_i = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v_o: got %b want 0", v_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_latency;
    do_reset();
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL lat_c0_v: got %b want 0", v_o); end
    cyc(1'b1, 8'hA5, 1'b0);
    for (int c = 1; c < LAT; c++) begin
      n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL lat_early_v c%0d: got %b want 0", c, v_o); end
      cyc(1'b0, '0, 1'b0);
    end
    for (int c = 0; c < 11; c++) begin
      n_checks++;
      if (v_o !== 1'b1 || data_o !== 8'hA5) begin
        n_fail++; $display("FAIL lat_hold c%0d: v_o=%b data=%h want 1/a5", c, v_o, data_o);
      end
      cyc(1'b0, '0, 1'b0);
    end
    cyc(1'b0, '0, 1'b1);
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL lat_empty: v_o=%b want 0", v_o); end
  endtask

  task automatic test_fill_drain;
    do_reset();
    for (int i = 0; i <= E; i++) begin
      n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready w%0d: got %b want 1", i, ready_o); end
      cyc(1'b1, W'(i), 1'b0);
    end
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_full: ready=%b want 0", ready_o); end
    // the first yumi issues a read, but ready_o stays low in that same cycle
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL drain_ready_d0: got %b want 0", ready_o); end
    for (int i = 0; i <= E; i++) begin
      n_checks++;
      if (v_o !== 1'b1 || data_o !== W'(i)) begin
        n_fail++; $display("FAIL drain_data i%0d: v_o=%b data=%h want 1/%h", i, v_o, data_o, W'(i));
      end
      cyc(1'b0, '0, 1'b1);
      if (i == 0) begin
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_ready_d1: got %b want 1", ready_o); end
      end
    end
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL drain_empty: v_o=%b want 0", v_o); end
  endtask

  task automatic test_back_to_back;
    int cnt, expv, started, bubbles, stalls, k;
    logic fire, y;
    do_reset();
    cnt = 0; expv = 0; started = 0; bubbles = 0; stalls = 0;
    for (int c = 0; c < 100; c++) begin
      y = v_o;
      if (v_o) begin
        started = 1;
        n_checks++;
        if (data_o !== W'(expv)) begin n_fail++; $display("FAIL b2b_data c%0d: got %h want %h", c, data_o, W'(expv)); end
        expv++;
      end else if (started != 0) bubbles++;
      fire = ready_o;
      if (!ready_o) stalls++;
      cyc(1'b1, W'(cnt), y);
      if (fire) cnt++;
    end
    n_checks++; if (bubbles != 0) begin n_fail++; $display("FAIL b2b_bubbles: got %0d want 0", bubbles); end
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
    n_checks++; if (expv != 100 - LAT) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", expv, 100 - LAT); end
    k = 0;
    while (v_o && k < 40) begin cyc(1'b0, '0, 1'b1); k++; end
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: v_o=%b want 0", v_o); end
  endtask

  task automatic test_random;
    logic [W-1:0] q[$];
    logic [W-1:0] d;
    logic v, y;
    int maxq, errs, k;
    do_reset();
    maxq = 0; errs = 0;
    for (int c = 0; c < 3000; c++) begin
      v = 1'($urandom % 2);
      d = W'($urandom);
      y = v_o & 1'($urandom % 2);
      if (y) begin
        if (q.size() == 0 || data_o !== q[0]) begin
          errs++;
          if (errs < 5) $display("FAIL rand_data c%0d: got %h want %h (q=%0d)", c, data_o, (q.size() > 0) ? q[0] : 8'h00, q.size());
        end
        if (q.size() > 0) void'(q.pop_front());
      end
      if (v && ready_o) q.push_back(d);
      if (q.size() > maxq) maxq = q.size();
      cyc(v, d, y);
    end
    k = 0;
    while (q.size() > 0 && k < 60) begin
      y = v_o;
      if (y) begin
        if (data_o !== q[0]) begin errs++; $display("FAIL rand_drain: got %h want %h", data_o, q[0]); end
        void'(q.pop_front());
      end
      cyc(1'b0, '0, y);
      k++;
    end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL rand_errors: got %0d want 0", errs); end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d want 0", q.size()); end
    n_checks++; if (maxq > E + 1) begin n_fail++; $display("FAIL rand_capacity: got %0d want <=%0d", maxq, E + 1); end
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL rand_empty: v_o=%b want 0", v_o); end
  endtask

  task automatic test_mid_reset;
    int k;
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b1, W'(8'h50 + i), 1'b0);
    reset_i = 1'b1;
    cyc(1'b1, 8'hEE, 1'b0);
    reset_i = 1'b0;
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL mrst_v_o: got %b want 0", v_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL mrst_ready: got %b want 1", ready_o); end
    cyc(1'b1, 8'h3C, 1'b0);
    k = 0;
    while (!v_o && k < 5) begin cyc(1'b0, '0, 1'b0); k++; end
    n_checks++;
    if (v_o !== 1'b1 || data_o !== 8'h3C) begin n_fail++; $display("FAIL mrst_data: v_o=%b data=%h want 1/3c", v_o, data_o); end
    cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0);
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL mrst_stale: v_o=%b data=%h want 0", v_o, data_o); end
  endtask

  task automatic test_full_simul;
    logic [W-1:0] e;
    do_reset();
    for (int i = 0; i <= E; i++) cyc(1'b1, W'(i), 1'b0);
    n_checks++;
    if (ready_o !== 1'b0 || data_o !== 8'h00) begin n_fail++; $display("FAIL fs_c0: ready=%b data=%h want 0/00", ready_o, data_o); end
    cyc(1'b1, 8'h99, 1'b1);   // rejected: still full this cycle
    n_checks++;
    if (ready_o !== 1'b1 || data_o !== 8'h01) begin n_fail++; $display("FAIL fs_c1: ready=%b data=%h want 1/01", ready_o, data_o); end
    cyc(1'b1, 8'h99, 1'b1);   // accepted
    for (int i = 0; i < E; i++) begin
      e = (i < E - 1) ? W'(i + 2) : 8'h99;
      n_checks++;
      if (v_o !== 1'b1 || data_o !== e) begin n_fail++; $display("FAIL fs_order i%0d: v_o=%b data=%h want 1/%h", i, v_o, data_o, e); end
      cyc(1'b0, '0, 1'b1);
    end
    n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL fs_empty: v_o=%b want 0 (dup)", v_o); end
  endtask

  initial begin
    #1;
    test_reset();
    test_latency();
    test_fill_drain();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_full_simul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
